// File: rtl/uart_rx_packet_ctrl.sv
// uart_rx_packet_ctrl: frame controller for the UART receive path.
// Parses SYNC, CMD, ADDR, LEN, payload[, checksum] from the receiver byte stream and turns
// each payload byte into a one-cycle buffer write one clock after its strobe.
// It reports frame completion or abort (inter-byte timeout or bad checksum) as one-cycle pulses.
// Optional feature: define UART_PKT_CKSUM_EN to add the trailing checksum byte and its check.
module uart_rx_packet_ctrl #(
    parameter int unsigned ADDR_W       = 8,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
    parameter int unsigned TIMEOUT_CLKS = 4340
) (
    input  logic              i_Clock,
    input  logic              i_Reset_n,
    input  logic              i_RX_DV,
    input  logic [7:0]        i_RX_Byte,
    output logic              o_Wr_En,
    output logic [ADDR_W-1:0] o_Wr_Addr,
    output logic [7:0]        o_Wr_Data,
    output logic [7:0]        o_Cmd,
    output logic              o_Frame_Done,
    output logic              o_Frame_Err,
    output logic              o_Busy
);

    // Counter must hold TIMEOUT_CLKS for the single cycle after expiry.
    localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CLKS - 1);

`ifdef UART_PKT_CKSUM_EN
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CMD   = 3'd1,
        S_ADDR  = 3'd2,
        S_LEN   = 3'd3,
        S_DATA  = 3'd4,
        S_CKSUM = 3'd5
    } state_e;
    // After the last payload byte (or LEN==0) the checksum byte is still owed.
    localparam state_e S_EOF = S_CKSUM;
`else
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CMD  = 3'd1,
        S_ADDR = 3'd2,
        S_LEN  = 3'd3,
        S_DATA = 3'd4
    } state_e;
    localparam state_e S_EOF = S_IDLE;
`endif

    state_e             state_q, state_d;
    logic [7:0]         cmd_q;
    logic [7:0]         base_q;
    logic [7:0]         len_q;
    logic [7:0]         idx_q;
    logic [CNT_W-1:0]   cnt_q;

    logic               timeout_hit;
    logic               last_byte;

    logic               wr_en_d;
    logic [ADDR_W-1:0]  wr_addr_d;
    logic [7:0]         wr_data_d;
    logic [7:0]         cmd_d;
    logic               done_d;
    logic               err_d;

    // A strobe on the expiry cycle wins over the timeout.
    assign timeout_hit = (state_q != S_IDLE) && !i_RX_DV && (cnt_q == CNT_LAST);

    // LEN==0 ends the frame at the LEN byte; otherwise the byte at index len-1 ends it.
    assign last_byte = ((state_q == S_LEN) && (i_RX_Byte == 8'h00)) ||
                       ((state_q == S_DATA) && (idx_q == len_q - 8'd1));

    assign o_Busy = (state_q != S_IDLE);

`ifdef UART_PKT_CKSUM_EN
    logic [7:0] sum_q;
    logic [7:0] cksum_total;

    assign cksum_total = sum_q + i_RX_Byte;

    // Running 8-bit sum over CMD, ADDR, LEN and payload; restarted at SYNC.
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            sum_q <= 8'h00;
        end else if (i_RX_DV) begin
            if (state_q == S_IDLE) begin
                sum_q <= 8'h00;
            end else if (state_q != S_CKSUM) begin
                sum_q <= sum_q + i_RX_Byte;
            end
        end
    end
`endif

    // State register.
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: one field per byte strobe, abort to idle on timeout.
    always_comb begin
        state_d = state_q;
        if (timeout_hit) begin
            state_d = S_IDLE;
        end else if (i_RX_DV) begin
            case (state_q)
                S_IDLE: begin
                    if (i_RX_Byte == SYNC_BYTE) begin
                        state_d = S_CMD;
                    end
                end
                S_CMD:  state_d = S_ADDR;
                S_ADDR: state_d = S_LEN;
                S_LEN, S_DATA: begin
                    if (last_byte) begin
                        state_d = S_EOF;
                    end else begin
                        state_d = S_DATA;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Header fields, payload index and inter-byte timeout counter.
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            cmd_q  <= 8'h00;
            base_q <= 8'h00;
            len_q  <= 8'h00;
            idx_q  <= 8'h00;
            cnt_q  <= '0;
        end else begin
            if (i_RX_DV || (state_q == S_IDLE)) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (i_RX_DV) begin
                case (state_q)
                    S_CMD:  cmd_q  <= i_RX_Byte;
                    S_ADDR: base_q <= i_RX_Byte;
                    S_LEN: begin
                        len_q <= i_RX_Byte;
                        idx_q <= 8'h00;
                    end
                    S_DATA: idx_q <= idx_q + 8'd1;
                    default: ;
                endcase
            end
        end
    end

    // Output next-values: write strobe, frame result pulses, held address/data/cmd.
    always_comb begin
        wr_en_d   = 1'b0;
        wr_addr_d = o_Wr_Addr;
        wr_data_d = o_Wr_Data;
        cmd_d     = o_Cmd;
        done_d    = 1'b0;
        err_d     = 1'b0;
        if (timeout_hit) begin
            err_d = 1'b1;
        end else if (i_RX_DV) begin
            if (state_q == S_DATA) begin
                wr_en_d   = 1'b1;
                // Base is zero-extended; the sum wraps modulo 2^ADDR_W.
                wr_addr_d = ADDR_W'(base_q) + ADDR_W'(idx_q);
                wr_data_d = i_RX_Byte;
            end
`ifdef UART_PKT_CKSUM_EN
            if (state_q == S_CKSUM) begin
                if (cksum_total == 8'h00) begin
                    done_d = 1'b1;
                    cmd_d  = cmd_q;
                end else begin
                    err_d = 1'b1;
                end
            end
`else
            if (last_byte) begin
                done_d = 1'b1;
                cmd_d  = cmd_q;
            end
`endif
        end
    end

    // Output registers.
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            o_Wr_En      <= 1'b0;
            o_Wr_Addr    <= '0;
            o_Wr_Data    <= 8'h00;
            o_Cmd        <= 8'h00;
            o_Frame_Done <= 1'b0;
            o_Frame_Err  <= 1'b0;
        end else begin
            o_Wr_En      <= wr_en_d;
            o_Wr_Addr    <= wr_addr_d;
            o_Wr_Data    <= wr_data_d;
            o_Cmd        <= cmd_d;
            o_Frame_Done <= done_d;
            o_Frame_Err  <= err_d;
        end
    end

endmodule

// File: tb/tb_uart_rx_packet_ctrl.sv
// Bench for uart_rx_packet_ctrl: directed frame table, hand-written timeout/reset sequences and
// randomized frames, all checked cycle by cycle against a frame-position reference model.
`timescale 1ns/1ps
module tb_uart_rx_packet_ctrl;

    localparam int unsigned ADDR_W = 8;
    localparam logic [7:0]  SYNC   = 8'hA5;
    localparam int          T      = 64;
`ifdef UART_PKT_CKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              rx_dv = 1'b0;
    logic [7:0]        rx_byte = 8'h00;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic [7:0]        cmd;
    logic              done;
    logic              err;
    logic              busy;

    uart_rx_packet_ctrl #(
        .ADDR_W       (ADDR_W),
        .SYNC_BYTE    (SYNC),
        .TIMEOUT_CLKS (T)
    ) dut (
        .i_Clock      (clk),
        .i_Reset_n    (rst_n),
        .i_RX_DV      (rx_dv),
        .i_RX_Byte    (rx_byte),
        .o_Wr_En      (wr_en),
        .o_Wr_Addr    (wr_addr),
        .o_Wr_Data    (wr_data),
        .o_Cmd        (cmd),
        .o_Frame_Done (done),
        .o_Frame_Err  (err),
        .o_Busy       (busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int n_wr = 0, n_done = 0, n_err = 0;

    // Reference model: position within the current frame, counted in bytes after SYNC.
    bit                m_in;
    int                m_n, m_len, m_base, m_cmd, m_sum, m_gap;
    logic [7:0]        e_cmd, e_data;
    logic [ADDR_W-1:0] e_addr;
    bit                e_wr, e_done, e_err;

    function automatic void model_reset();
        m_in = 0; m_n = 0; m_len = 0; m_base = 0; m_cmd = 0; m_sum = 0; m_gap = 0;
        e_cmd = 8'h00; e_data = 8'h00; e_addr = '0;
        e_wr = 0; e_done = 0; e_err = 0;
    endfunction

    function automatic void model_step(input bit dv, input logic [7:0] b);
        e_wr = 0; e_done = 0; e_err = 0;
        if (!dv) begin
            if (m_in) begin
                m_gap++;
                if (m_gap >= T) begin
                    e_err = 1;
                    m_in  = 0;
                end
            end
            return;
        end
        if (!m_in) begin
            if (b == SYNC) begin
                m_in = 1; m_n = 0; m_sum = 0; m_gap = 0;
            end
            return;
        end
        m_gap = 0;
        m_n++;
        if (m_n == 1) m_cmd = int'(b);
        if (m_n == 2) m_base = int'(b);
        if (m_n == 3) m_len = int'(b);
        if (m_n >= 4 && m_n <= 3 + m_len) begin
            e_wr   = 1;
            e_addr = ADDR_W'(m_base + m_n - 4);
            e_data = b;
        end
        if (CK) begin
            if (m_n >= 4 && m_n == 4 + m_len) begin
                if (((m_sum + int'(b)) % 256) == 0) begin
                    e_done = 1;
                    e_cmd  = 8'(m_cmd);
                end else begin
                    e_err = 1;
                end
                m_in = 0;
            end else begin
                m_sum = (m_sum + int'(b)) % 256;
            end
        end else if (m_n >= 3 && m_n == 3 + m_len) begin
            e_done = 1;
            e_cmd  = 8'(m_cmd);
            m_in   = 0;
        end
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // One clock with the given input; outputs compared against the model 1 ns after the edge.
    task automatic step(input bit dv, input logic [7:0] b);
        rx_dv   = dv;
        rx_byte = b;
        @(posedge clk);
        #1;
        model_step(dv, b);
        check("cycle {wr,done,err,busy,cmd,addr,data}",
              {wr_en, done, err, busy, cmd, wr_addr, wr_data},
              {e_wr, e_done, e_err, m_in, e_cmd, e_addr, e_data});
        n_wr   += int'(wr_en);
        n_done += int'(done);
        n_err  += int'(err);
        rx_dv = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'($urandom));
    endtask

    task automatic clear_counts();
        n_wr = 0; n_done = 0; n_err = 0;
    endtask

    // Directed vectors: bytes right-aligned, first byte sent is the most significant.
    typedef struct {
        logic [95:0] b;
        int          nb;
        int          gap;
        int          wr;
        int          dn;
        int          er;
        logic [7:0]  cmd;
        logic [7:0]  addr;
        logic [7:0]  data;
    } vec_t;
    vec_t tbl[6];

    initial begin
        #900us;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] bq[$];
        int         len, s;

`ifdef UART_PKT_CKSUM_EN
        tbl[0] = '{b:96'hA501100311223386, nb:8, gap:4, wr:3, dn:1, er:0,
                   cmd:8'h01, addr:8'h12, data:8'h33};
        tbl[1] = '{b:96'h00FFA5070000F9, nb:7, gap:4, wr:0, dn:1, er:0,
                   cmd:8'h07, addr:8'h12, data:8'h33};
        tbl[2] = '{b:96'hA502FE04DEADBEEFC4, nb:9, gap:4, wr:4, dn:1, er:0,
                   cmd:8'h02, addr:8'h01, data:8'hEF};
        tbl[3] = '{b:96'hA501100120CE, nb:6, gap:4, wr:1, dn:1, er:0,
                   cmd:8'h01, addr:8'h10, data:8'h20};
        tbl[4] = '{b:96'hA509100120C7, nb:6, gap:4, wr:1, dn:0, er:1,
                   cmd:8'h01, addr:8'h10, data:8'h20};
        tbl[5] = '{b:96'hA5030005, nb:4, gap:T+4, wr:0, dn:0, er:1,
                   cmd:8'h01, addr:8'h10, data:8'h20};
`else
        tbl[0] = '{b:96'hA5011003112233, nb:7, gap:4, wr:3, dn:1, er:0,
                   cmd:8'h01, addr:8'h12, data:8'h33};
        tbl[1] = '{b:96'h00FFA5070000, nb:6, gap:4, wr:0, dn:1, er:0,
                   cmd:8'h07, addr:8'h12, data:8'h33};
        tbl[2] = '{b:96'hA502FE04DEADBEEF, nb:8, gap:4, wr:4, dn:1, er:0,
                   cmd:8'h02, addr:8'h01, data:8'hEF};
        tbl[3] = '{b:96'hA5030005, nb:4, gap:T+4, wr:0, dn:0, er:1,
                   cmd:8'h02, addr:8'h01, data:8'hEF};
        tbl[4] = '{b:96'hA5011003112233, nb:7, gap:4, wr:3, dn:1, er:0,
                   cmd:8'h01, addr:8'h12, data:8'h33};
        tbl[5] = '{b:96'hA509200177, nb:5, gap:4, wr:1, dn:1, er:0,
                   cmd:8'h09, addr:8'h20, data:8'h77};
`endif

        // Reset state.
        model_reset();
        #1;
        check("reset outputs", {wr_en, done, err, busy, cmd, wr_addr, wr_data}, 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Directed table.
        for (int r = 0; r < 6; r++) begin
            clear_counts();
            for (int i = 0; i < tbl[r].nb; i++) begin
                step(1'b1, tbl[r].b[8*(tbl[r].nb-1-i) +: 8]);
            end
            idle(tbl[r].gap);
            check($sformatf("row%0d wr count", r), 64'(n_wr), 64'(tbl[r].wr));
            check($sformatf("row%0d done count", r), 64'(n_done), 64'(tbl[r].dn));
            check($sformatf("row%0d err count", r), 64'(n_err), 64'(tbl[r].er));
            check($sformatf("row%0d cmd", r), 64'(cmd), 64'(tbl[r].cmd));
            check($sformatf("row%0d addr", r), 64'(wr_addr), 64'(tbl[r].addr));
            check($sformatf("row%0d data", r), 64'(wr_data), 64'(tbl[r].data));
            check($sformatf("row%0d busy", r), 64'(busy), 64'd0);
        end

        // Strobes landing exactly on the expiry cycle keep the frame alive.
        clear_counts();
        step(1'b1, SYNC); step(1'b1, 8'h03); step(1'b1, 8'h00); step(1'b1, 8'h02);
        idle(T - 1);
        step(1'b1, 8'h55);
        idle(T - 1);
        step(1'b1, 8'h66);
        if (CK) begin
            idle(T - 1);
            step(1'b1, 8'h40);
        end
        idle(3);
        check("expiry-cycle DV err count", 64'(n_err), 64'd0);
        check("expiry-cycle DV done count", 64'(n_done), 64'd1);
        check("expiry-cycle DV cmd", 64'(cmd), 64'h03);

        // One clock later than that is a timeout.
        clear_counts();
        step(1'b1, SYNC); step(1'b1, 8'h04); step(1'b1, 8'h00); step(1'b1, 8'h02);
        idle(T);
        check("one-past-expiry err count", 64'(n_err), 64'd1);
        check("one-past-expiry busy", 64'(busy), 64'd0);
        idle(2);

        // Reset in the middle of the payload.
        clear_counts();
        step(1'b1, SYNC); step(1'b1, 8'h0B); step(1'b1, 8'h30); step(1'b1, 8'h05);
        step(1'b1, 8'h01); step(1'b1, 8'h02);
        rst_n = 1'b0;
        #2;
        check("mid-frame reset outputs", {wr_en, done, err, busy, cmd, wr_addr, wr_data}, 64'd0);
        @(posedge clk);
        #1;
        check("held reset outputs", {wr_en, done, err, busy, cmd, wr_addr, wr_data}, 64'd0);
        rst_n = 1'b1;
        model_reset();
        clear_counts();
        idle(3);
        for (int i = 0; i < tbl[0].nb; i++) step(1'b1, tbl[0].b[8*(tbl[0].nb-1-i) +: 8]);
        idle(2);
        check("post-reset frame done", 64'(n_done), 64'd1);
        check("post-reset frame err", 64'(n_err), 64'd0);
        check("post-reset cmd", 64'(cmd), 64'h01);

        // Randomized frames with noise, occasional long gaps and bad checksums.
        for (int f = 0; f < 150; f++) begin
            bq.delete();
            for (int i = 0; i < int'($urandom_range(0, 2)); i++) begin
                bq.push_back(8'($urandom_range(0, 8'hA4)));
            end
            bq.push_back(SYNC);
            len = int'($urandom_range(0, 12));
            bq.push_back(8'($urandom));
            bq.push_back(8'($urandom));
            bq.push_back(8'(len));
            for (int i = 0; i < len; i++) begin
                bq.push_back(($urandom_range(0, 9) == 0) ? SYNC : 8'($urandom));
            end
            if (CK) begin
                s = 0;
                for (int i = 1; i < bq.size(); i++) begin
                    if (i > 0 && bq[i-1] == SYNC && s == 0 && i <= 3) s = 0;
                end
                s = 0;
                for (int i = bq.size() - 3 - len; i < bq.size(); i++) s += int'(bq[i]);
                s = (256 - (s % 256)) % 256;
                if ($urandom_range(0, 4) == 0) s = (s + 1) % 256;
                bq.push_back(8'(s));
            end
            foreach (bq[i]) begin
                if ($urandom_range(0, 32) == 0) idle(int'($urandom_range(T - 2, T + 2)));
                else idle(int'($urandom_range(0, 2)));
                step(1'b1, bq[i]);
            end
            idle(int'($urandom_range(0, 3)));
        end
        idle(T + 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
